// File: rtl/bnn_pkg.sv
// Shared defaults, binarization mode codes and the frame-state type for the
// BNN stream feeder.
package bnn_pkg;

  localparam int N_CLASS_DEF    = 10;
  localparam int KTAPS_DEF      = 9;
  localparam int N_KERN_DEF     = 2;
  localparam int IMG_PIXELS_DEF = 784;

  // Binarization modes: sign of the MSB, or an unsigned threshold compare.
  localparam int BIN_MSB    = 0;
  localparam int BIN_THRESH = 1;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frame_state_t;

endpackage

// File: rtl/bnn_pix_binarizer.sv
// Pixel path: accepts pixel bytes while a frame is active, binarizes them into
// a single output register stage and flags consumption of the frame's last pixel.
module bnn_pix_binarizer
  import bnn_pkg::*;
#(
  parameter int PIX_W      = 8,
  parameter int BIN_MODE   = BIN_MSB,
  parameter int THRESH     = 128,
  parameter int IMG_PIXELS = IMG_PIXELS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             active,
  input  logic             frame_go,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_in_valid,
  output logic             pix_in_ready,
  output logic             pix_bit,
  output logic             pix_valid,
  input  logic             pix_out_ready,
  output logic             last_done
);

  localparam int CW = $clog2(IMG_PIXELS + 1);
  localparam logic [CW-1:0]    FRAME_CNT = CW'(IMG_PIXELS);
  localparam logic [PIX_W-1:0] THR       = PIX_W'(THRESH);

  logic [CW-1:0] acc_cnt;
  logic          accept;
  logic          consume;
  logic          bin_bit;

  // Once all pixels of the frame are accepted, the register holds the last one,
  // so its consumption is the end of the frame.
  assign pix_in_ready = active && (!pix_valid || pix_out_ready) && (acc_cnt < FRAME_CNT);
  assign accept       = pix_in_valid && pix_in_ready;
  assign consume      = pix_valid && pix_out_ready;
  assign last_done    = active && consume && (acc_cnt == FRAME_CNT);

  always_comb begin
    bin_bit = 1'b0;
    if (BIN_MODE == BIN_THRESH) bin_bit = (pix_in < THR);
    else                        bin_bit = ~pix_in[PIX_W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_cnt   <= '0;
      pix_bit   <= 1'b0;
      pix_valid <= 1'b0;
    end else begin
      if (frame_go)    acc_cnt <= '0;
      else if (accept) acc_cnt <= acc_cnt + 1'b1;

      if (accept) begin
        pix_bit   <= bin_bit;
        pix_valid <= 1'b1;
      end else if (consume) begin
        pix_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/bnn_stream_feeder.sv
// On-chip feeder for the BNN accelerator: frame control, binarized pixel stream,
// per-kernel conv weight taps and a synchronous-read FC weight memory.
module bnn_stream_feeder
  import bnn_pkg::*;
#(
  parameter int N_CLASS    = N_CLASS_DEF,
  parameter int FC_LEN     = 1152,
  parameter int N_KERN     = N_KERN_DEF,
  parameter int KTAPS      = KTAPS_DEF,
  parameter int IMG_PIXELS = IMG_PIXELS_DEF,
  parameter int PIX_W      = 8,
  parameter int BIN_MODE   = BIN_MSB,
  parameter int THRESH     = 128,
  localparam int AW = $clog2((FC_LEN > N_KERN) ? FC_LEN : N_KERN),
  localparam int DW = (N_CLASS > KTAPS) ? N_CLASS : KTAPS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               wr_en,
  input  logic               wr_sel,
  input  logic [AW-1:0]      wr_addr,
  input  logic [DW-1:0]      wr_data,
  input  logic [PIX_W-1:0]   pix_in,
  input  logic               pix_in_valid,
  output logic               pix_in_ready,
  output logic               pix_bit,
  output logic               pix_valid,
  input  logic               pix_out_ready,
  output logic               img_done,
  input  logic [N_KERN-1:0]  weight_en,
  output logic               conv_w_bit,
  output logic               conv_err,
  input  logic               fc_ivalid,
  output logic [N_CLASS-1:0] fc_w,
  output logic               fc_last,
  output logic               busy
);

  localparam int FAW = (FC_LEN > 1) ? $clog2(FC_LEN) : 1;
  localparam int TW  = (KTAPS > 1) ? $clog2(KTAPS) : 1;
  localparam int KW  = (N_KERN > 1) ? $clog2(N_KERN) : 1;
  localparam logic [AW-1:0]  N_KERN_A = AW'(N_KERN);
  localparam logic [AW-1:0]  FC_LEN_A = AW'(FC_LEN);
  localparam logic [FAW-1:0] FC_LAST  = FAW'(FC_LEN - 1);
  localparam logic [TW-1:0]  TAP_LAST = TW'(KTAPS - 1);

  frame_state_t state_q, state_d;
  logic         frame_go;
  logic         last_done;

  logic [KTAPS-1:0]   kern   [N_KERN];
  logic [TW-1:0]      tap    [N_KERN];
  logic [N_CLASS-1:0] fc_mem [FC_LEN];
  logic [FAW-1:0]     fc_addr;

  logic          conv_wr;
  logic          fc_wr;
  logic          conv_hit;
  logic          conv_multi;
  logic [KW-1:0] conv_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    frame_go = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = ACTIVE;
          frame_go = 1'b1;
        end
      end
      ACTIVE: begin
        if (last_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q == ACTIVE);
  assign img_done = last_done;

  bnn_pix_binarizer #(
    .PIX_W      (PIX_W),
    .BIN_MODE   (BIN_MODE),
    .THRESH     (THRESH),
    .IMG_PIXELS (IMG_PIXELS)
  ) u_pix (
    .clk           (clk),
    .rst           (rst),
    .active        (busy),
    .frame_go      (frame_go),
    .pix_in        (pix_in),
    .pix_in_valid  (pix_in_valid),
    .pix_in_ready  (pix_in_ready),
    .pix_bit       (pix_bit),
    .pix_valid     (pix_valid),
    .pix_out_ready (pix_out_ready),
    .last_done     (last_done)
  );

  assign conv_wr = wr_en && !wr_sel && (wr_addr < N_KERN_A);
  assign fc_wr   = wr_en &&  wr_sel && (wr_addr < FC_LEN_A);

  // Weight storage keeps its contents across reset.
  always_ff @(posedge clk) begin
    if (conv_wr) kern[wr_addr[KW-1:0]] <= wr_data[KTAPS-1:0];
    if (fc_wr)   fc_mem[wr_addr[FAW-1:0]] <= wr_data[N_CLASS-1:0];
  end

  // With several enables high the lowest index wins.
  always_comb begin
    conv_hit   = |weight_en;
    conv_multi = |(weight_en & (weight_en - N_KERN'(1)));
    conv_sel   = '0;
    for (int k = N_KERN - 1; k >= 0; k--) begin
      if (weight_en[k]) conv_sel = KW'(k);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_KERN; k++) tap[k] <= '0;
      conv_w_bit <= 1'b0;
      conv_err   <= 1'b0;
    end else begin
      for (int k = 0; k < N_KERN; k++) begin
        if (frame_go || (conv_wr && (wr_addr == AW'(k))))
          tap[k] <= '0;
        else if (conv_hit && (conv_sel == KW'(k)))
          tap[k] <= (tap[k] == TAP_LAST) ? '0 : tap[k] + 1'b1;
      end
      if (conv_hit)   conv_w_bit <= kern[conv_sel][tap[conv_sel]];
      if (conv_multi) conv_err   <= 1'b1;
    end
  end

  // Same-address write and read in one cycle returns the pre-write word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fc_addr <= '0;
      fc_w    <= '0;
      fc_last <= 1'b0;
    end else begin
      if (frame_go)       fc_addr <= '0;
      else if (fc_ivalid) fc_addr <= (fc_addr == FC_LAST) ? '0 : fc_addr + 1'b1;

      if (fc_ivalid) begin
        fc_w    <= fc_mem[fc_addr];
        fc_last <= (fc_addr == FC_LAST);
      end else begin
        fc_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bnn_stream_feeder.sv
// Self-checking bench for bnn_stream_feeder: randomized stimulus compared against
// a queue/array reference model of the pixel, conv and FC weight paths.
module tb_bnn_stream_feeder;

  localparam int N_CLASS    = 10;
  localparam int FC_LEN     = 1152;
  localparam int N_KERN     = 2;
  localparam int KTAPS      = 9;
  localparam int IMG_PIXELS = 784;
  localparam int PIX_W      = 8;
  localparam int AW         = 11;
  localparam int DW         = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic               wr_en;
  logic               wr_sel;
  logic [AW-1:0]      wr_addr;
  logic [DW-1:0]      wr_data;
  logic [PIX_W-1:0]   pix_in;
  logic               pix_in_valid;
  logic               pix_in_ready;
  logic               pix_bit;
  logic               pix_valid;
  logic               pix_out_ready;
  logic               img_done;
  logic [N_KERN-1:0]  weight_en;
  logic               conv_w_bit;
  logic               conv_err;
  logic               fc_ivalid;
  logic [N_CLASS-1:0] fc_w;
  logic               fc_last;
  logic               busy;

  int vectors     = 0;
  int miscompares = 0;

  // Reference-model state for the conv path.
  logic [KTAPS-1:0] km [N_KERN];
  int               mtap [N_KERN];
  logic             last_bit;

  logic [N_CLASS-1:0] fc_model [FC_LEN];

  bnn_stream_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .wr_en         (wr_en),
    .wr_sel        (wr_sel),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .pix_in        (pix_in),
    .pix_in_valid  (pix_in_valid),
    .pix_in_ready  (pix_in_ready),
    .pix_bit       (pix_bit),
    .pix_valid     (pix_valid),
    .pix_out_ready (pix_out_ready),
    .img_done      (img_done),
    .weight_en     (weight_en),
    .conv_w_bit    (conv_w_bit),
    .conv_err      (conv_err),
    .fc_ivalid     (fc_ivalid),
    .fc_w          (fc_w),
    .fc_last       (fc_last),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // A pixel reads as 1 when it is in the darker half of the 8-bit range.
  function automatic logic ref_bin(logic [7:0] v);
    return (v < 8'd128);
  endfunction

  task automatic idle_inputs();
    start = 0; wr_en = 0; wr_sel = 0; wr_addr = '0; wr_data = '0;
    pix_in = '0; pix_in_valid = 0; pix_out_ready = 0; weight_en = '0; fc_ivalid = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    pix_in = 8'h10; pix_in_valid = 1; weight_en = 2'b11;
    @(negedge clk);
    pix_in_valid = 0; weight_en = '0;
    vectors++;
    if ({busy, pix_valid, pix_bit, conv_err} !== 4'b1111) begin
      miscompares++;
      $display("[TB] FAIL reset_pre_state {busy,pix_valid,pix_bit,conv_err}: got %b expected 1111",
               {busy, pix_valid, pix_bit, conv_err});
    end
    #2 rst = 1;
    #1;
    vectors++;
    if ({busy, pix_valid, pix_bit, pix_in_ready, img_done, conv_w_bit, conv_err, fc_last, fc_w} !== 18'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %b expected all zero",
               {busy, pix_valid, pix_bit, pix_in_ready, img_done, conv_w_bit, conv_err, fc_last, fc_w});
    end
    @(negedge clk) rst = 0;
  endtask

  task automatic test_binarize();
    logic [7:0] pv [4];
    logic       exp_b [4];
    pv = '{8'h00, 8'hFF, 8'h80, 8'h7F};
    for (int i = 0; i < 4; i++) exp_b[i] = ref_bin(pv[i]);
    do_reset();
    // Input while idle must be refused.
    pix_in = 8'h00; pix_in_valid = 1; pix_out_ready = 1;
    #1;
    vectors++;
    if (pix_in_ready !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_ready: got %b expected 0", pix_in_ready);
    end
    @(negedge clk);
    pix_in_valid = 0;
    vectors++;
    if (pix_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL idle_no_accept: got %b expected 0", pix_valid);
    end
    start = 1;
    @(negedge clk) start = 0;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if ({pix_valid, pix_bit} !== {1'b1, exp_b[i-1]}) begin
          miscompares++;
          $display("[TB] FAIL binarize_%0d {valid,bit}: got %b expected %b", i - 1,
                   {pix_valid, pix_bit}, {1'b1, exp_b[i-1]});
        end
      end
      if (i < 4) begin
        pix_in = pv[i]; pix_in_valid = 1;
        #1;
        vectors++;
        if (pix_in_ready !== 1'b1) begin
          miscompares++;
          $display("[TB] FAIL binarize_ready_%0d: got %b expected 1", i, pix_in_ready);
        end
      end else begin
        pix_in_valid = 0;
      end
    end
    @(negedge clk);
    vectors++;
    if (pix_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL binarize_drain: got %b expected 0", pix_valid);
    end
  endtask

  task automatic test_full_frame();
    logic q [$];
    logic exp;
    int   sent = 0, got = 0, dones = 0, cyc = 0;
    do_reset();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    while (got < IMG_PIXELS && cyc < 10000) begin
      @(negedge clk);
      cyc++;
      pix_out_ready = cyc[0];
      pix_in_valid  = (sent < IMG_PIXELS) && ($urandom_range(0, 3) != 0);
      pix_in        = 8'($urandom_range(0, 255));
      #1;
      if (img_done) dones++;
      if (pix_valid && pix_out_ready) begin
        got++;
        if (q.size() == 0) begin
          vectors++; miscompares++;
          $display("[TB] FAIL frame_extra_pixel: got valid pixel %0d expected none pending", got);
        end else begin
          exp = q.pop_front();
          vectors++;
          if (pix_bit !== exp) begin
            miscompares++;
            $display("[TB] FAIL frame_pix_%0d: got %b expected %b", got, pix_bit, exp);
          end
        end
        vectors++;
        if (img_done !== (got == IMG_PIXELS)) begin
          miscompares++;
          $display("[TB] FAIL frame_img_done_%0d: got %b expected %b", got, img_done, got == IMG_PIXELS);
        end
      end
      if (pix_in_valid && pix_in_ready) begin
        q.push_back(ref_bin(pix_in));
        sent++;
      end
    end
    vectors++;
    if (got != IMG_PIXELS || dones != 1) begin
      miscompares++;
      $display("[TB] FAIL frame_totals handshakes/img_done: got %0d/%0d expected %0d/1", got, dones, IMG_PIXELS);
    end
    pix_in_valid = 1;
    pix_out_ready = 1;
    @(negedge clk);
    #1;
    vectors++;
    if ({busy, pix_in_ready, pix_valid, img_done} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL frame_end {busy,ready,valid,done}: got %b expected 0000",
               {busy, pix_in_ready, pix_valid, img_done});
    end
    @(negedge clk);
    pix_in_valid = 0;
    vectors++;
    if (pix_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL frame_after_end_valid: got %b expected 0", pix_valid);
    end
  endtask

  task automatic test_conv_wrap();
    logic exp;
    do_reset();
    km[0] = 9'b1_0101_0101;
    km[1] = 9'($urandom);
    mtap[0] = 0; mtap[1] = 0;
    for (int k = 0; k < N_KERN; k++) begin
      @(negedge clk);
      wr_en = 1; wr_sel = 0; wr_addr = AW'(k); wr_data = {1'b0, km[k]};
    end
    @(negedge clk) wr_en = 0;
    for (int k = 0; k < N_KERN; k++) begin
      int n = (k == 0) ? 10 : 12;
      for (int i = 0; i <= n; i++) begin
        @(negedge clk);
        if (i > 0) begin
          vectors++;
          if (conv_w_bit !== exp) begin
            miscompares++;
            $display("[TB] FAIL conv_k%0d_step%0d: got %b expected %b", k, i - 1, conv_w_bit, exp);
          end
        end
        if (i < n) begin
          weight_en = N_KERN'(1) << k;
          exp = km[k][mtap[k]];
          mtap[k] = (mtap[k] + 1) % KTAPS;
        end else begin
          weight_en = '0;
        end
      end
    end
    // With no enable the last bit is held.
    @(negedge clk);
    vectors++;
    if (conv_w_bit !== exp) begin
      miscompares++;
      $display("[TB] FAIL conv_hold: got %b expected %b", conv_w_bit, exp);
    end
    last_bit = exp;
  endtask

  task automatic test_conv_conflict();
    logic [1:0]       steps [5];
    logic [KTAPS-1:0] kn;
    logic             exp_bit, exp_err;
    int               sel;
    steps = '{2'b11, 2'b10, 2'b00, 2'b00, 2'b01};
    exp_bit = last_bit;
    exp_err = 0;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        vectors++;
        if ({conv_err, conv_w_bit} !== {exp_err, exp_bit}) begin
          miscompares++;
          $display("[TB] FAIL conflict_step%0d {err,bit}: got %b expected %b", i - 1,
                   {conv_err, conv_w_bit}, {exp_err, exp_bit});
        end
      end
      if (i < 5) begin
        weight_en = steps[i];
        if (steps[i] != 2'b00) begin
          sel = steps[i][0] ? 0 : 1;
          exp_bit = km[sel][mtap[sel]];
          mtap[sel] = (mtap[sel] + 1) % KTAPS;
          if (steps[i] == 2'b11) exp_err = 1;
        end
      end else begin
        weight_en = '0;
      end
    end
    do_reset();
    vectors++;
    if ({conv_err, conv_w_bit} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL conflict_cleared_by_reset: got %b expected 00", {conv_err, conv_w_bit});
    end
    // An out-of-range kernel index must not disturb stored kernels.
    wr_en = 1; wr_sel = 0; wr_addr = AW'(N_KERN); wr_data = {1'b0, ~km[0]};
    @(negedge clk);
    wr_en = 0; weight_en = 2'b01;
    @(negedge clk);
    weight_en = '0;
    vectors++;
    if (conv_w_bit !== km[0][0]) begin
      miscompares++;
      $display("[TB] FAIL conv_kept_after_reset: got %b expected %b", conv_w_bit, km[0][0]);
    end
    weight_en = 2'b01;
    kn = 9'($urandom);
    kn[0] = ~kn[2];
    @(negedge clk);
    weight_en = '0; wr_en = 1; wr_sel = 0; wr_addr = '0; wr_data = {1'b0, kn};
    @(negedge clk);
    wr_en = 0; weight_en = 2'b01;
    @(negedge clk);
    weight_en = '0;
    vectors++;
    if (conv_w_bit !== kn[0]) begin
      miscompares++;
      $display("[TB] FAIL conv_write_resets_tap: got %b expected %b", conv_w_bit, kn[0]);
    end
  endtask

  task automatic test_fc_readback();
    logic [N_CLASS-1:0] exp_w, hold_w;
    logic               exp_last;
    int                 ptr = 0, reads = 0, cyc = 0;
    bit                 pending = 0;
    do_reset();
    for (int a = 0; a < FC_LEN; a++) begin
      @(negedge clk);
      wr_en = 1; wr_sel = 1; wr_addr = AW'(a); wr_data = DW'(a % 1024);
      fc_model[a] = N_CLASS'(a % 1024);
    end
    @(negedge clk) wr_en = 0;
    hold_w = '0;
    while ((reads < FC_LEN + 1 || pending) && cyc < 6000) begin
      @(negedge clk);
      cyc++;
      vectors++;
      if (pending) begin
        if ({fc_last, fc_w} !== {exp_last, exp_w}) begin
          miscompares++;
          $display("[TB] FAIL fc_read_%0d {last,word}: got %b_%0d expected %b_%0d", reads - 1,
                   fc_last, fc_w, exp_last, exp_w);
        end
        hold_w = exp_w;
      end else if ({fc_last, fc_w} !== {1'b0, hold_w}) begin
        miscompares++;
        $display("[TB] FAIL fc_idle_hold {last,word}: got %b_%0d expected 0_%0d", fc_last, fc_w, hold_w);
      end
      if (reads < FC_LEN + 1 && $urandom_range(0, 3) != 0) begin
        fc_ivalid = 1;
        exp_w = fc_model[ptr];
        exp_last = (ptr == FC_LEN - 1);
        ptr = (ptr + 1) % FC_LEN;
        reads++;
        pending = 1;
      end else begin
        fc_ivalid = 0;
        pending = 0;
      end
    end
    fc_ivalid = 0;
    vectors++;
    if (reads != FC_LEN + 1 || pending) begin
      miscompares++;
      $display("[TB] FAIL fc_read_budget: got %0d reads expected %0d", reads, FC_LEN + 1);
    end
    // start rewinds the read pointer; same-address write returns the old word.
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    fc_ivalid = 1; wr_en = 1; wr_sel = 1; wr_addr = '0; wr_data = 10'h3AA;
    exp_w = fc_model[0];
    fc_model[0] = 10'h3AA;
    @(negedge clk);
    vectors++;
    if (fc_w !== exp_w) begin
      miscompares++;
      $display("[TB] FAIL fc_same_addr_old: got %0h expected %0h", fc_w, exp_w);
    end
    wr_addr = AW'(2); wr_data = 10'h155;
    exp_w = fc_model[1];
    fc_model[2] = 10'h155;
    @(negedge clk);
    vectors++;
    if (fc_w !== exp_w) begin
      miscompares++;
      $display("[TB] FAIL fc_after_start: got %0h expected %0h", fc_w, exp_w);
    end
    wr_en = 0;
    exp_w = fc_model[2];
    @(negedge clk);
    fc_ivalid = 0;
    vectors++;
    if (fc_w !== exp_w) begin
      miscompares++;
      $display("[TB] FAIL fc_write_next_cycle: got %0h expected %0h", fc_w, exp_w);
    end
    do_reset();
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_binarize();
    test_full_frame();
    test_conv_wrap();
    test_conv_conflict();
    test_fc_readback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bnn_stream_feeder.md
Name: bnn_stream_feeder

Overview:
- Synthesizable replacement for the bench-side file readers that feed the BNN accelerator top.
- Holds conv-kernel and FC-class weight bits in on-chip storage, loaded via a host write port.
- Binarizes an incoming pixel byte stream and serves weight bits on the accelerator's request strobes (one-hot per-kernel enables, FC valid).
- Generalised over class count, kernel count/size, image size, pixel width and binarization mode.

Parameters:
- N_CLASS, 10, number of FC output classes; the FC weight word is N_CLASS bits.
- FC_LEN, 1152, FC weight words per class vector; depth of the FC memory.
- N_KERN, 2, number of conv kernels.
- KTAPS, 9, bits per conv kernel (3x3).
- IMG_PIXELS, 784, pixels per frame.
- PIX_W, 8, input pixel width.
- BIN_MODE, 0, binarization mode: 0 gives bit = ~pix[PIX_W-1]; 1 gives bit = (pix < THRESH).
- THRESH, 128, compare threshold used when BIN_MODE=1.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; arms a new frame.
- wr_en  in  1  host weight write strobe.
- wr_sel  in  1  write target: 0 = conv, 1 = FC.
- wr_addr  in  clog2(max(FC_LEN,N_KERN))  FC word index, or conv kernel index.
- wr_data  in  max(N_CLASS,KTAPS)  FC word (low N_CLASS bits) or kernel bits (low KTAPS bits; bit0 = first tap).
- pix_in  in  PIX_W  pixel byte.
- pix_in_valid  in  1  pixel valid.
- pix_in_ready  out  1  pixel accepted when valid && ready.
- pix_bit  out  1  binarized pixel.
- pix_valid  out  1  pix_bit valid.
- pix_out_ready  in  1  downstream accepts pix_bit.
- img_done  out  1  one-cycle pulse when the last pixel of a frame is consumed downstream.
- weight_en  in  N_KERN  one-hot conv weight request.
- conv_w_bit  out  1  conv weight bit.
- conv_err  out  1  sticky flag: more than one weight_en bit was seen high.
- fc_ivalid  in  1  FC weight request.
- fc_w  out  N_CLASS  FC weight word, bit i = class i.
- fc_last  out  1  marks the word at index FC_LEN-1.
- busy  out  1  frame active.

Behaviour:
- Reset: all outputs 0, all counters 0, weight storage contents unchanged (not reset), state IDLE.
- Frame FSM, states IDLE and ACTIVE:
  - IDLE -> ACTIVE on start; pixel counter clears.
  - ACTIVE -> IDLE when the pixel with index IMG_PIXELS-1 is consumed downstream (pix_valid && pix_out_ready); img_done pulses in that same cycle.
  - start while ACTIVE is ignored.
  - busy = (state == ACTIVE).
- Pixel path: single output register stage.
  - pix_in_ready = ACTIVE && (!pix_valid || pix_out_ready) && (accepted count < IMG_PIXELS).
  - On accept, pix_bit is registered with latency 1, pix_valid=1.
  - pix_valid clears when consumed and no new pixel is accepted.
  - Input arriving while IDLE is never accepted.
- Conv path:
  - One tap counter per kernel, range 0..KTAPS-1.
  - Cycle with weight_en[k]=1: conv_w_bit <= kern[k][tap_k] (latency 1); tap_k increments and wraps KTAPS-1 -> 0.
  - More than one enable bit high: lowest index is served, other counters hold, conv_err <= 1 until reset.
  - No enable: conv_w_bit holds.
- FC path:
  - On fc_ivalid: fc_w <= mem[fc_addr], fc_last <= (fc_addr == FC_LEN-1), both latency 1; fc_addr wraps FC_LEN-1 -> 0.
  - No fc_ivalid: fc_w holds, fc_last <= 0.
- Host writes:
  - Allowed at any time; effective the next cycle.
  - Write and read to the same FC address in the same cycle: the read returns old data.
  - Conv write to kernel k resets tap_k to 0.
  - Out-of-range addresses are ignored.
- start also clears all tap counters and fc_addr.
- rst asserted mid-frame aborts the frame immediately; no img_done is produced.

Decomposition:
- Shared package bnn_pkg holds: N_CLASS, KTAPS, N_KERN, IMG_PIXELS defaults; the frame-state enum; the BIN_MODE constants.
- Sub-module bnn_pix_binarizer: the pixel path (PIX_W, BIN_MODE, THRESH) with its ready/valid register stage.
- The FC memory is inferred inline as a synchronous-read RAM.

Test Plan:
- Reset values: assert rst mid-cycle -> every output 0 asynchronously; busy=0.
- Pixel binarization, BIN_MODE=0: after start, stream 0x00, 0xFF, 0x80, 0x7F with pix_out_ready=1 -> pix_bit = 1, 0, 0, 1, each one cycle after accept.
- Full frame with backpressure: 784 pixels, pix_out_ready toggled every other cycle -> exactly 784 pix_valid handshakes, one img_done on the 784th, then busy=0 and pix_in_ready=0.
- Conv wrap: write kernel0 = 9'b1_0101_0101, then hold weight_en=2'b01 for 10 cycles -> conv_w_bit = 1,0,1,0,1,0,1,0,1,1.
- Conv conflict: weight_en=2'b11 -> kernel0 served, tap1 unchanged, conv_err=1 until rst.
- FC readback: load words 0..FC_LEN-1 with the value addr mod 1024, then issue FC_LEN+1 fc_ivalid pulses -> sequence 0,1,...; fc_last=1 only on word FC_LEN-1; the final word is word 0 again.
